// File: rtl/asip_pkg.sv
// Shared definitions for the RSA-decryption ASIP: opcodes, instruction field
// positions, branch codes and the fetch-stage state encoding.
package asip_pkg;

  // Opcode map carried in instruction bits [23:21]
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_CMP = 3'd1;
  localparam logic [2:0] OP_LDR = 3'd2;
  localparam logic [2:0] OP_STR = 3'd3;
  localparam logic [2:0] OP_JEQ = 3'd4;
  localparam logic [2:0] OP_JNE = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  // Instruction field positions
  localparam int OPC_HI = 23;
  localparam int OPC_LO = 21;
  localparam int FN_HI  = 20;
  localparam int FN_LO  = 19;

  // Bubble word presented to decode when nothing live is held
  localparam logic [23:0] NOP_INSTR = {OP_NOP, 21'b0};

  // Branch code produced by the control unit
  typedef enum logic [1:0] {
    BR_EQ   = 2'b00,
    BR_NE   = 2'b01,
    BR_AL   = 2'b10,
    BR_NONE = 2'b11
  } br_code_e;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch resolution: decides whether a control-flow
// instruction is taken and selects the next PC (target or sequential).
module branch_resolve
  import asip_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              br_valid_i,
  input  logic [1:0]        br_code_i,
  input  logic              br_zero_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic [ADDR_W-1:0] seq_pc_i,
  output logic              taken_o,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic is_al;
  logic is_eq;
  logic is_ne;

  assign is_al = (br_code_i == 2'(BR_AL));
  assign is_eq = (br_code_i == 2'(BR_EQ));
  assign is_ne = (br_code_i == 2'(BR_NE));

  // BR_NONE falls through every term, so it can never be taken
  assign taken_o   = br_valid_i & (is_al | (is_eq & br_zero_i) | (is_ne & ~br_zero_i));
  assign next_pc_o = taken_o ? br_target_i : seq_pc_i;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding reads to
// instruction memory, holds the fetched word in the IF/ID register and
// redirects on taken branches, discarding any in-flight stale fetch.
module fetch_unit
  import asip_pkg::*;
#(
  parameter int               ADDR_W   = 10,
  parameter int               INSTR_W  = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               br_valid,
  input  logic [1:0]         br_code,
  input  logic               br_zero,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [2:0]         opcode,
  output logic [1:0]         funct,
  output logic               redirect
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic [ADDR_W-1:0]  seq_pc;
  logic               drop_q;
  logic               if_valid_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic [ADDR_W-1:0]  if_pc_q;
  logic               redirect_q;

  logic consume;
  logic room;
  logic ack_live;
  logic taken;

  assign consume  = if_valid_q & ~stall;
  assign room     = ~if_valid_q | consume;
  // An ack that carries a word we actually want (not a pre-redirect fetch)
  assign ack_live = (state_q == WAIT) & imem_ack & ~drop_q;
  // PC advances only when a wanted word lands; wraps naturally at ADDR_W bits
  assign seq_pc   = ack_live ? (pc_q + 1'b1) : pc_q;

  branch_resolve #(
    .ADDR_W(ADDR_W)
  ) u_branch_resolve (
    .br_valid_i (br_valid),
    .br_code_i  (br_code),
    .br_zero_i  (br_zero),
    .br_target_i(br_target),
    .seq_pc_i   (seq_pc),
    .taken_o    (taken),
    .next_pc_o  (pc_d)
  );

  // Request only from REQ with somewhere to put the answer; never while in reset
  assign imem_req  = (state_q == REQ) & room & ~rst;
  assign imem_addr = pc_q;

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign redirect = redirect_q;
  assign opcode   = if_valid_q ? if_instr_q[OPC_HI:OPC_LO] : OP_NOP;
  assign funct    = if_valid_q ? if_instr_q[FN_HI:FN_LO]   : 2'd0;

  // Fetch sequencer, PC, drop flag and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= taken;
      pc_q       <= pc_d;

      // A redirect kills the held word and wins over stall and over a new load
      if (taken) begin
        if_valid_q <= 1'b0;
      end else if (ack_live) begin
        if_valid_q <= 1'b1;
        if_instr_q <= imem_rdata;
        if_pc_q    <= pc_q;
      end else if (consume) begin
        if_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (room) begin
            state_q <= WAIT;
            // The request going out now is for the old PC
            if (taken) drop_q <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            drop_q  <= 1'b0;
            state_q <= REQ;
          end else if (taken) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
